// File: rtl/commit_trace_buffer_pkg.sv
// trace_pkg: shared types for the commit trace buffer.
//   KIND_GRF / KIND_DM : event kind encodings
//   trace_entry_t      : one FIFO entry {kind, pc, addr, data}, 97 bits
package trace_pkg;

   localparam logic KIND_GRF = 1'b0;
   localparam logic KIND_DM  = 1'b1;

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trace_entry_t;

   localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: valid/ready drain port of the commit trace buffer.
//   out_valid  head entry available
//   out_ready  consumer accepts head
//   out_kind   0 = GRF, 1 = DM
//   out_pc     event PC
//   out_addr   register number (zero-extended) or DM address
//   out_data   written value
// master = trace buffer, slave = trace consumer.
interface commit_trace_buffer_if;

   logic        out_valid;
   logic        out_ready;
   logic        out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_addr;
   logic [31:0] out_data;

   modport master (
      output out_valid, out_kind, out_pc, out_addr, out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_kind, out_pc, out_addr, out_data,
      output out_ready
   );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo_2w1r: FIFO with two push ports and one pop port.
//   clk, reset        clock, async active-high reset
//   push0/push0_data  first (older) push
//   push1/push1_data  second push; only honoured together with push0
//   pop               remove head entry (ignored while empty)
//   head              registered head entry, zero while empty
//   level             occupancy 0..DEPTH
// The caller is responsible for never pushing more than the free space.
module trace_fifo_2w1r
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push0,
   input  trace_entry_t      push0_data,
   input  logic              push1,
   input  trace_entry_t      push1_data,
   input  logic              pop,
   output trace_entry_t      head,
   output logic [PTR_W:0]    level
);

   trace_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [PTR_W:0]     level_q, level_d;
   logic [PTR_W-1:0]   wptr_plus1;
   logic               push1_ok;
   logic               pop_ok;
   logic [1:0]         push_cnt;

   assign push1_ok   = push0 && push1;
   assign pop_ok     = pop && (level_q != '0);
   assign push_cnt   = {1'b0, push0} + {1'b0, push1_ok};
   assign wptr_plus1 = wptr_q + PTR_W'(1);

   always_comb begin
      wptr_d  = wptr_q + PTR_W'(push_cnt);
      rptr_d  = pop_ok ? rptr_q + PTR_W'(1) : rptr_q;
      level_d = level_q + {{(PTR_W-1){1'b0}}, push_cnt} - {{PTR_W{1'b0}}, pop_ok};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push0)
         mem[wptr_q] <= push0_data;
      if (push1_ok)
         mem[wptr_plus1] <= push1_data;
   end

   assign head  = (level_q != '0) ? mem[rptr_q] : '0;
   assign level = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: records retired GRF writes (W stage) and DM stores
// (M stage) into a dual-push FIFO drained over a valid/ready port.
//   clk, reset           clock, async active-high reset
//   grf_we/pc/addr/wdata W-stage register write (writes to $0 ignored)
//   dm_we/pc/addr/wdata  M-stage store
//   out_if               drain port (commit_trace_buffer_if.master)
//   overflow             sticky, set when any event is dropped
//   level                current occupancy
//   drop_cnt             saturating count of dropped events
//                        (only when TRACE_DROP_CNT_EN is defined)
// Same-cycle events are ordered GRF then DM (the W instruction is older).
// Free space is taken before this cycle's pop, so a pop never makes room
// for a push in the same cycle.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 grf_we,
   input  logic [31:0]          grf_pc,
   input  logic [4:0]           grf_addr,
   input  logic [31:0]          grf_wdata,
   input  logic                 dm_we,
   input  logic [31:0]          dm_pc,
   input  logic [31:0]          dm_addr,
   input  logic [31:0]          dm_wdata,
   commit_trace_buffer_if.master out_if,
   output logic                 overflow,
   output logic [PTR_W:0]       level
`ifdef TRACE_DROP_CNT_EN
   ,
   output logic [15:0]          drop_cnt
`endif
);

   logic           grf_q_ev, dm_q_ev;
   logic [PTR_W:0] free;
   logic           push_grf, push_dm;
   logic           drop_grf, drop_dm;
   logic           push0, push1;
   trace_entry_t   grf_entry, dm_entry;
   trace_entry_t   push0_data;
   trace_entry_t   head;
   logic           pop;
   logic           overflow_q, overflow_d;

   assign grf_q_ev = grf_we && (grf_addr != 5'd0);
   assign dm_q_ev  = dm_we;

   assign free     = (PTR_W+1)'(DEPTH) - level;
   assign push_grf = grf_q_ev && (free != '0);
   // DM needs a second slot when a GRF event takes the first one.
   assign push_dm  = dm_q_ev && (grf_q_ev ? (free > (PTR_W+1)'(1)) : (free != '0));
   assign drop_grf = grf_q_ev && !push_grf;
   assign drop_dm  = dm_q_ev && !push_dm;

   always_comb begin
      grf_entry.kind = KIND_GRF;
      grf_entry.pc   = grf_pc;
      grf_entry.addr = {27'd0, grf_addr};
      grf_entry.data = grf_wdata;
      dm_entry.kind  = KIND_DM;
      dm_entry.pc    = dm_pc;
      dm_entry.addr  = dm_addr;
      dm_entry.data  = dm_wdata;
   end

   // Compact the accepted events onto the FIFO ports: slot 0 always holds
   // the oldest accepted event.
   assign push0      = push_grf || push_dm;
   assign push1      = push_grf && push_dm;
   assign push0_data = push_grf ? grf_entry : dm_entry;

   assign pop = out_if.out_valid && out_if.out_ready;

   trace_fifo_2w1r #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push0      (push0),
      .push0_data (push0_data),
      .push1      (push1),
      .push1_data (dm_entry),
      .pop        (pop),
      .head       (head),
      .level      (level)
   );

   assign out_if.out_valid = (level != '0);
   assign out_if.out_kind  = head.kind;
   assign out_if.out_pc    = head.pc;
   assign out_if.out_addr  = head.addr;
   assign out_if.out_data  = head.data;

   assign overflow_d = overflow_q || drop_grf || drop_dm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow_q <= 1'b0;
      else
         overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;

`ifdef TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_grf} + {15'd0, drop_dm};

   always_comb begin
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_cnt_q <= 16'd0;
      else
         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
   import trace_pkg::*;

   logic        clk;
   logic        reset;
   logic        grf_we;
   logic [31:0] grf_pc;
   logic [4:0]  grf_addr;
   logic [31:0] grf_wdata;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        overflow;
   logic [4:0]  level;
`ifdef TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int checks;
   int errors;

   commit_trace_buffer_if tr_if ();

   commit_trace_buffer #(.DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .grf_we    (grf_we),
      .grf_pc    (grf_pc),
      .grf_addr  (grf_addr),
      .grf_wdata (grf_wdata),
      .dm_we     (dm_we),
      .dm_pc     (dm_pc),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .out_if    (tr_if),
      .overflow  (overflow),
      .level     (level)
`ifdef TRACE_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      grf_we    = 1'b0;
      grf_pc    = '0;
      grf_addr  = '0;
      grf_wdata = '0;
      dm_we     = 1'b0;
      dm_pc     = '0;
      dm_addr   = '0;
      dm_wdata  = '0;
   endtask

   task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
      grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = d;
   endtask

   task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
      dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tr_if.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++; if (tr_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tr_if.out_valid); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (tr_if.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", tr_if.out_pc); end
   endtask

   task automatic test_single_grf();
      set_grf(32'h3000, 5'd5, 32'h1234);
      tick();
      idle_inputs();
      checks++; if (tr_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", tr_if.out_valid); end
      checks++; if (tr_if.out_kind !== KIND_GRF) begin errors++; $display("FAIL single_kind got %b want 0", tr_if.out_kind); end
      checks++; if (tr_if.out_addr !== 32'd5) begin errors++; $display("FAIL single_addr got %h want 5", tr_if.out_addr); end
      checks++; if (tr_if.out_data !== 32'h1234) begin errors++; $display("FAIL single_data got %h want 1234", tr_if.out_data); end
      checks++; if (tr_if.out_pc !== 32'h3000) begin errors++; $display("FAIL single_pc got %h want 3000", tr_if.out_pc); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
      tr_if.out_ready = 1'b1;
      tick();
      tr_if.out_ready = 1'b0;
      checks++; if (level !== 5'd0 || tr_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain level %0d valid %b want 0 0", level, tr_if.out_valid); end
   endtask

   task automatic test_zero_filter();
      set_grf(32'h3100, 5'd0, 32'hDEAD);
      tick();
      idle_inputs();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL zero_level got %0d want 0", level); end
      checks++; if (tr_if.out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b want 0", tr_if.out_valid); end
   endtask

   task automatic test_dual_push();
      set_grf(32'h3004, 5'd7, 32'hAA);
      set_dm(32'h3008, 32'h10, 32'hFF);
      tr_if.out_ready = 1'b1;
      tick();
      idle_inputs();
      checks++; if (level !== 5'd2) begin errors++; $display("FAIL dual_level0 got %0d want 2", level); end
      checks++; if (tr_if.out_kind !== KIND_GRF || tr_if.out_pc !== 32'h3004 || tr_if.out_addr !== 32'd7 || tr_if.out_data !== 32'hAA)
         begin errors++; $display("FAIL dual_first kind %b pc %h addr %h data %h want 0 3004 7 aa", tr_if.out_kind, tr_if.out_pc, tr_if.out_addr, tr_if.out_data); end
      tick();
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL dual_level1 got %0d want 1", level); end
      checks++; if (tr_if.out_kind !== KIND_DM || tr_if.out_pc !== 32'h3008 || tr_if.out_addr !== 32'h10 || tr_if.out_data !== 32'hFF)
         begin errors++; $display("FAIL dual_second kind %b pc %h addr %h data %h want 1 3008 10 ff", tr_if.out_kind, tr_if.out_pc, tr_if.out_addr, tr_if.out_data); end
      tick();
      tr_if.out_ready = 1'b0;
      checks++; if (level !== 5'd0 || tr_if.out_valid !== 1'b0) begin errors++; $display("FAIL dual_empty level %0d valid %b want 0 0", level, tr_if.out_valid); end
   endtask

   task automatic test_fill_overflow();
      tr_if.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_grf(32'h4000 + 32'(4*i), 5'(i+1), 32'(i));
         tick();
      end
      idle_inputs();
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got %b want 0", overflow); end
      set_grf(32'h4800, 5'd9, 32'h99);
      set_dm(32'h4804, 32'h20, 32'h77);
      tick();
      idle_inputs();
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %b want 1", overflow); end
      checks++; if (tr_if.out_pc !== 32'h4000 || tr_if.out_addr !== 32'd1) begin errors++; $display("FAIL full_head pc %h addr %h want 4000 1", tr_if.out_pc, tr_if.out_addr); end
`ifdef TRACE_DROP_CNT_EN
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL full_drop_cnt got %0d want 2", drop_cnt); end
`endif
   endtask

   task automatic test_partial_drop();
      tr_if.out_ready = 1'b1;
      tick();
      checks++; if (level !== 5'd15) begin errors++; $display("FAIL partial_pre_level got %0d want 15", level); end
      set_grf(32'h5000, 5'd3, 32'h55);
      set_dm(32'h5004, 32'h30, 32'h66);
      tick();
      idle_inputs();
      tr_if.out_ready = 1'b0;
      checks++; if (level !== 5'd15) begin errors++; $display("FAIL partial_level got %0d want 15", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL partial_overflow got %b want 1", overflow); end
      checks++; if (tr_if.out_pc !== 32'h4008) begin errors++; $display("FAIL partial_head pc %h want 4008", tr_if.out_pc); end
`ifdef TRACE_DROP_CNT_EN
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL partial_drop_cnt got %0d want 3", drop_cnt); end
`endif
      tr_if.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      tr_if.out_ready = 1'b0;
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL partial_tail_level got %0d want 1", level); end
      checks++; if (tr_if.out_kind !== KIND_GRF || tr_if.out_pc !== 32'h5000 || tr_if.out_data !== 32'h55)
         begin errors++; $display("FAIL partial_tail kind %b pc %h data %h want 0 5000 55", tr_if.out_kind, tr_if.out_pc, tr_if.out_data); end
      tr_if.out_ready = 1'b1;
      tick();
      tr_if.out_ready = 1'b0;
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL partial_drained got %0d want 0", level); end
   endtask

   task automatic test_async_reset();
      tr_if.out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_grf(32'h6000 + 32'(4*i), 5'(i+10), 32'(i));
         tick();
      end
      idle_inputs();
      checks++; if (level !== 5'd7) begin errors++; $display("FAIL async_pre_level got %0d want 7", level); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL async_level got %0d want 0", level); end
      checks++; if (tr_if.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", tr_if.out_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got %b want 0", overflow); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_grf();
      test_zero_filter();
      test_dual_push();
      test_fill_overflow();
      test_partial_drop();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Captures architectural write events that the pipelined MIPS core retires: GRF writes from the W stage and DM stores from the M stage. Events go into a dual-push, single-pop FIFO and drain to a trace consumer over a valid/ready port. The block sits beside `mips` at the top level and receives the same `clk`/`reset` the bench drives. It reads the core's write-side information so that retirement traces can be compared without changing the datapath.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4
- PTR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- grf_we  in  1  W-stage GRF write enable
- grf_pc  in  32  PC of the W-stage instruction
- grf_addr  in  5  destination register
- grf_wdata  in  32  write data
- dm_we  in  1  M-stage store enable
- dm_pc  in  32  PC of the M-stage instruction
- dm_addr  in  32  byte address, word-aligned by the core
- dm_wdata  in  32  store data
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_kind  out  1  0 = GRF, 1 = DM
- out_pc  out  32  event PC
- out_addr  out  32  register number, zero-extended, or DM address
- out_data  out  32  written value
- overflow  out  1  sticky: at least one event was dropped
- level  out  PTR_W+1  current occupancy

## Operation
- GRF event qualified by grf_we && grf_addr != 0. Writes to $0 are never recorded.
- DM event qualified by dm_we.
- Same-cycle GRF and DM events are pushed GRF first, then DM, because the W instruction is older.
- Free slots = DEPTH − level, sampled before this cycle's pop. A pop in the same cycle does not create room for a push.
- If free slots ≥ number of qualified events, push all of them.
- If free = 1 and two events are qualified, push the GRF event, drop the DM event, and set overflow.
- If free = 0, drop all qualified events and set overflow.
- Pop occurs when out_valid && out_ready. The head advances by 1.
- Pointers wrap modulo DEPTH. level stays in the range 0..DEPTH.
- overflow clears only on reset.

## Timing
- Reset values: out_valid=0, level=0, overflow=0. Pointers are 0. out_kind/out_pc/out_addr/out_data are 0 while empty.
- Push latency is 1 cycle: an event sampled at edge N gives out_valid=1 after edge N if the FIFO was empty.
- out_* are driven combinationally from the registered head entry. They hold stable while out_valid && !out_ready.
- Per edge: level_next = level + pushes − pop, where pushes ∈ {0,1,2}.
- Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.
- Throughput: 1 pop per cycle sustained. A burst of 2 pushes per cycle is absorbed up to DEPTH.

## Configuration
- TRACE_DROP_CNT_EN defined: adds output `drop_cnt` [15:0].
  - Increments by the number of events dropped that cycle (1 or 2).
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Undefined: no counter; only the sticky overflow flag reports loss.

## Structure
- Package `trace_pkg`:
  - KIND_GRF=1'b0, KIND_DM=1'b1
  - packed struct `trace_entry_t` {kind, pc, addr, data}, 97 bits
- Sub-module `trace_fifo_2w1r`: storage array, pointers, level, and the push/pop arithmetic, with two push ports and one pop port.
- Top-level `commit_trace_buffer`: event qualification, ordering, drop logic, overflow flag and the optional counter.

## Test plan
- Reset then a single GRF write: grf_we=1, addr=5, wdata=32'h1234, pc=32'h3000. Next cycle: out_valid=1, kind=0, addr=5, data=32'h1234, pc=32'h3000, level=1.
- $0 filter: grf_we=1, addr=0 → level stays 0 and out_valid stays 0.
- Dual push: GRF (pc 32'h3004) and DM (pc 32'h3008, addr 32'h10, data 32'hFF) in the same cycle, with out_ready=1. Output shows the GRF event, then the DM event on consecutive cycles; level goes 2→1→0.
- Fill with out_ready=0, 16 single pushes → level=16. Then one dual event: both dropped, overflow=1, and drop_cnt=2 when TRACE_DROP_CNT_EN is defined. Head entry is unchanged.
- level=15 with a dual event and pop in the same cycle: GRF event kept, DM event dropped, level=15 next cycle, overflow=1.
- Assert reset asynchronously between edges with level=7: level=0, out_valid=0 and overflow=0 immediately, before the next edge.
